// File: rtl/regfile_scoreboard_pkg.sv
// Shared definitions for the register file / scoreboard and the pipeline
// stages around it: default geometry plus the register index and data types
// used by decode and writeback.
package regfile_scoreboard_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NRD    = 2;

  typedef logic [DEF_ADDR_W-1:0] reg_idx_t;
  typedef logic [DEF_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_read_port.sv
// One read port of the register file. It applies hardwired-zero masking,
// forwards same-cycle writeback data and qualifies the pending flag so that a
// forwarded value is never reported as busy.
module regfile_read_port
  import regfile_scoreboard_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic [ADDR_W-1:0] ra,
  input  logic [DATA_W-1:0] stored,
  input  logic              pending,
  input  logic              regwr,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] out,
  output logic              busy
);

  logic is_zero;
  logic is_fwd;

  // Select stored, forwarded or zero data and the matching busy flag.
  always_comb begin
    is_zero = (ZERO_REG != 0) && (ra == {ADDR_W{1'b0}});
    is_fwd  = (BYPASS != 0) && regwr && (rd == ra);
    out     = stored;
    busy    = pending;
    if (is_zero) begin
      out  = {DATA_W{1'b0}};
      busy = 1'b0;
    end else if (is_fwd) begin
      out  = data;
      busy = 1'b0;
    end else begin
      out  = stored;
      busy = pending;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Parametrised register file with asynchronous reads, write-to-read bypass,
// optional hardwired-zero register and a per-register pending scoreboard with
// a running count of outstanding producers.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NRD      = DEF_NRD,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    regwr,
  input  logic [ADDR_W-1:0]       rd,
  input  logic [DATA_W-1:0]       data,
  input  logic [NRD*ADDR_W-1:0]   ra,
  output logic [NRD*DATA_W-1:0]   out,
  output logic [(1<<ADDR_W)-1:0]  decode,
  input  logic                    issue_en,
  input  logic [ADDR_W-1:0]       issue_rd,
  output logic [NRD-1:0]          busy,
  output logic                    stall,
  output logic [ADDR_W:0]         pend_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pending;
  logic [DEPTH-1:0]  pending_nxt;
  logic [DEPTH-1:0]  wr_onehot;
  logic [DEPTH-1:0]  set_mask;
  logic [ADDR_W:0]   cnt_nxt;
  logic              wr_ok;
  logic              set_ok;
  logic              set_new;
  logic              clr_eff;

  // Qualify write and claim against the zero register, then build the next
  // scoreboard state; a claim overrides a same-cycle clear of that register.
  always_comb begin
    wr_onehot   = regwr ? ({{(DEPTH-1){1'b0}}, 1'b1} << rd) : {DEPTH{1'b0}};
    wr_ok       = regwr && !((ZERO_REG != 0) && (rd == {ADDR_W{1'b0}}));
    set_ok      = issue_en && !((ZERO_REG != 0) && (issue_rd == {ADDR_W{1'b0}}));
    set_mask    = set_ok ? ({{(DEPTH-1){1'b0}}, 1'b1} << issue_rd) : {DEPTH{1'b0}};
    set_new     = set_ok && !pending[issue_rd];
    clr_eff     = regwr && pending[rd] && !(set_ok && (issue_rd == rd));
    pending_nxt = (pending & ~wr_onehot) | set_mask;
    cnt_nxt     = pend_cnt + {{ADDR_W{1'b0}}, set_new} - {{ADDR_W{1'b0}}, clr_eff};
    decode      = wr_onehot;
  end

  // Register storage: cleared by reset, written on a qualified writeback.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= {DATA_W{1'b0}};
      end
    end else if (wr_ok) begin
      regs[rd] <= data;
    end
  end

  // Scoreboard bits and outstanding-producer count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending  <= {DEPTH{1'b0}};
      pend_cnt <= {(ADDR_W+1){1'b0}};
    end else begin
      pending  <= pending_nxt;
      pend_cnt <= cnt_nxt;
    end
  end

  for (genvar gi = 0; gi < NRD; gi++) begin : g_port
    logic [ADDR_W-1:0] port_ra;
    assign port_ra = ra[gi*ADDR_W +: ADDR_W];

    regfile_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_port (
      .ra      (port_ra),
      .stored  (regs[port_ra]),
      .pending (pending[port_ra]),
      .regwr   (regwr),
      .rd      (rd),
      .data    (data),
      .out     (out[gi*DATA_W +: DATA_W]),
      .busy    (busy[gi])
    );
  end

  assign stall = |busy;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: a default instance (zero register, bypass)
// and a second instance without zero register or bypass share one stimulus
// stream and are each compared against an array-based model.
module tb_regfile_scoreboard;

  logic        clk;
  logic        reset;
  logic        regwr;
  logic [4:0]  rd;
  logic [31:0] data;
  logic [9:0]  ra;
  logic        issue_en;
  logic [4:0]  issue_rd;

  logic [63:0] out0, out1;
  logic [31:0] decode0, decode1;
  logic [1:0]  busy0, busy1;
  logic        stall0, stall1;
  logic [5:0]  cnt0, cnt1;

  int compared = 0;
  int failed   = 0;

  logic [31:0] mreg  [2][32];
  bit          mpend [2][32];

  regfile_scoreboard dut0 (
    .clk(clk), .reset(reset), .regwr(regwr), .rd(rd), .data(data), .ra(ra),
    .out(out0), .decode(decode0), .issue_en(issue_en), .issue_rd(issue_rd),
    .busy(busy0), .stall(stall0), .pend_cnt(cnt0)
  );

  regfile_scoreboard #(.ZERO_REG(0), .BYPASS(0)) dut1 (
    .clk(clk), .reset(reset), .regwr(regwr), .rd(rd), .data(data), .ra(ra),
    .out(out1), .decode(decode1), .issue_en(issue_en), .issue_rd(issue_rd),
    .busy(busy1), .stall(stall1), .pend_cnt(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit zr(int k);
    return (k == 0);
  endfunction

  function automatic bit bp(int k);
    return (k == 0);
  endfunction

  function automatic logic [31:0] exp_out(int k, logic [4:0] a);
    if (zr(k) && a == 5'd0) return 32'd0;
    if (bp(k) && regwr && rd == a) return data;
    return mreg[k][a];
  endfunction

  function automatic logic exp_busy(int k, logic [4:0] a);
    if (zr(k) && a == 5'd0) return 1'b0;
    if (bp(k) && regwr && rd == a) return 1'b0;
    return mpend[k][a];
  endfunction

  function automatic int exp_cnt(int k);
    int c = 0;
    for (int a = 0; a < 32; a++) c += int'(mpend[k][a]);
    return c;
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 32; a++) begin
        mreg[k][a]  = 32'd0;
        mpend[k][a] = 1'b0;
      end
  endfunction

  function automatic void model_edge();
    if (reset) begin
      model_clear();
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (regwr && !(zr(k) && rd == 5'd0)) mreg[k][rd] = data;
        if (regwr) mpend[k][rd] = 1'b0;
        if (issue_en && !(zr(k) && issue_rd == 5'd0)) mpend[k][issue_rd] = 1'b1;
      end
    end
  endfunction

  task automatic chk(string tag, string what, int k, int p, logic [63:0] obs, logic [63:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s_%s i%0d p%0d observed=%0h expected=%0h", tag, what, k, p, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    for (int k = 0; k < 2; k++) begin
      logic [63:0] o;
      logic [1:0]  b;
      logic [31:0] d;
      logic        s;
      logic [5:0]  c;
      logic        es;
      if (k == 0) begin
        o = out0; b = busy0; d = decode0; s = stall0; c = cnt0;
      end else begin
        o = out1; b = busy1; d = decode1; s = stall1; c = cnt1;
      end
      es = 1'b0;
      for (int p = 0; p < 2; p++) begin
        chk(tag, "out", k, p, o[p*32 +: 32], exp_out(k, ra[p*5 +: 5]));
        chk(tag, "busy", k, p, b[p], exp_busy(k, ra[p*5 +: 5]));
        es = es | exp_busy(k, ra[p*5 +: 5]);
      end
      chk(tag, "stall", k, 0, s, es);
      chk(tag, "decode", k, 0, d, regwr ? (32'd1 << rd) : 32'd0);
      chk(tag, "pend_cnt", k, 0, c, 64'(exp_cnt(k)));
    end
  endtask

  // Check outputs mid-cycle, then take one rising edge and update the model.
  task automatic cycle(string tag);
    if (reset) model_clear();
    #2;
    check_all(tag);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    regwr = 1'b0; rd = 5'd0; data = 32'd0; ra = 10'd0;
    issue_en = 1'b0; issue_rd = 5'd0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    model_clear();
    #1;
    cycle("rst");
    chk("rst_lit", "out", 0, 0, out0, 64'd0);
    chk("rst_lit", "cnt", 0, 0, cnt0, 64'd0);
    cycle("rst");
    reset = 1'b0;
    cycle("idle");

    // Fill r1..r31 with i+2.
    for (int i = 1; i < 32; i++) begin
      regwr = 1'b1; rd = 5'(i); data = 32'(i + 2); ra = {5'd31, 5'd5};
      cycle("fill");
    end
    idle();
    ra = {5'd31, 5'd5};
    #1;
    chk("fill_r5", "out", 0, 0, out0[31:0], 64'd7);
    chk("fill_r31", "out", 0, 1, out0[63:32], 64'd33);
    cycle("fill_rd");
    ra = {5'd0, 5'd0};
    cycle("r0");

    // Write to r0 with ra0=0.
    regwr = 1'b1; rd = 5'd0; data = 32'hDEADBEEF; ra = 10'd0;
    #1;
    chk("r0wr", "out", 0, 0, out0[31:0], 64'd0);
    chk("r0wr", "decode", 0, 0, decode0, 64'h1);
    cycle("r0wr");
    idle();
    cycle("r0after");
    chk("r0after_nozero", "out", 1, 0, out1[31:0], 64'hDEADBEEF);

    // Bypass of r9.
    regwr = 1'b1; rd = 5'd9; data = 32'h11;
    cycle("r9a");
    regwr = 1'b1; rd = 5'd9; data = 32'h55; ra = {5'd0, 5'd9};
    #1;
    chk("byp", "out", 0, 0, out0[31:0], 64'h55);
    chk("byp", "busy", 0, 0, busy0[0], 64'd0);
    chk("nobyp", "out", 1, 0, out1[31:0], 64'h11);
    cycle("byp");
    idle(); ra = {5'd0, 5'd9};
    cycle("byp_next");
    chk("nobyp_next", "out", 1, 0, out1[31:0], 64'h55);

    // Claim r4 then write it back.
    issue_en = 1'b1; issue_rd = 5'd4;
    cycle("iss4");
    idle(); ra = {5'd4, 5'd0};
    #1;
    chk("iss4", "busy", 0, 1, busy0[1], 64'd1);
    chk("iss4", "stall", 0, 0, stall0, 64'd1);
    chk("iss4", "cnt", 0, 0, cnt0, 64'd1);
    cycle("iss4b");
    regwr = 1'b1; rd = 5'd4; data = 32'h44; ra = {5'd4, 5'd0};
    #1;
    chk("wb4", "busy", 0, 1, busy0[1], 64'd0);
    chk("wb4_nobyp", "busy", 1, 1, busy1[1], 64'd1);
    cycle("wb4");
    idle();
    cycle("wb4after");
    chk("wb4after", "cnt", 0, 0, cnt0, 64'd0);

    // Set wins over clear; claims of r0.
    issue_en = 1'b1; issue_rd = 5'd7;
    cycle("iss7");
    issue_en = 1'b1; issue_rd = 5'd7; regwr = 1'b1; rd = 5'd7; data = 32'h70;
    cycle("iss7wb");
    idle(); ra = {5'd7, 5'd7};
    #1;
    chk("iss7wb", "cnt", 0, 0, cnt0, 64'd1);
    chk("iss7wb", "busy", 0, 1, busy0[1], 64'd1);
    issue_en = 1'b1; issue_rd = 5'd0;
    cycle("iss0");
    idle();
    #1;
    chk("iss0", "cnt", 0, 0, cnt0, 64'd1);
    chk("iss0_nozero", "cnt", 1, 0, cnt1, 64'd2);
    cycle("iss0b");

    // Async reset between edges while r3 pending and r3=0x77.
    issue_en = 1'b1; issue_rd = 5'd3; regwr = 1'b1; rd = 5'd3; data = 32'h77;
    cycle("r3");
    idle(); ra = {5'd3, 5'd3};
    #1;
    chk("r3pre", "out", 0, 0, out0[31:0], 64'h77);
    reset = 1'b1;
    #1;
    chk("arst", "out", 0, 0, out0, 64'd0);
    chk("arst", "busy", 0, 0, busy0, 64'd0);
    chk("arst", "cnt", 0, 0, cnt0, 64'd0);
    cycle("arst");
    reset = 1'b0;
    cycle("arst_rel");

    // Randomised traffic.
    for (int n = 0; n < 400; n++) begin
      reset    = ($urandom_range(63) == 0);
      regwr    = 1'($urandom_range(1));
      rd       = 5'($urandom);
      data     = $urandom;
      issue_en = 1'($urandom_range(1));
      issue_rd = ($urandom_range(3) == 0) ? rd : 5'($urandom_range(7));
      ra       = 10'($urandom);
      if ($urandom_range(3) == 0) ra[4:0] = rd;
      if ($urandom_range(3) == 0) ra[9:5] = issue_rd;
      cycle("rnd");
    end
    reset = 1'b0;
    idle();
    cycle("end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
